sub_pixel_out_serializer: RTL

//  Receive end of the sub-pixel delay path. Accepts one 4-lane word per cycle of U13.9

---
 rtl/sub_pixel_out_serializer.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sub_pixel_out_serializer.sv
// ---------------------------------------------------------------------------
// sub_pixel_out_serializer
//   Receive end of the sub-pixel delay path. Each accepted 4-lane word of
//   U13.9 pixels is rounded to 14-bit integers in a registered stage, written
//   into a small word FIFO, and then emitted one pixel per valid/ready
//   transfer (lane 0 first) together with its index in the line and an
//   end-of-line flag.
//
// Ports
//   clk            clock, all logic on posedge
//   reset          asynchronous active-low reset
//   in_v/in_ready  input word handshake (in_v while !in_ready drops the word)
//   in_lane0..3    U13.9 interpolated pixels, lane 0 = earliest
//   pix_out        rounded serial pixel (registered)
//   pix_out_v      pix_out valid (registered)
//   pix_out_rdy    downstream ready
//   pix_idx        pixel index within the line (registered)
//   eol            high with the pixel at index LINE_LEN-1 (registered)
//   ovf            sticky dropped-word flag
//   ovf_clr        synchronous clear of ovf (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module sub_pixel_out_serializer #(
    parameter int DEPTH    = 4,
    parameter int LINE_LEN = 512,
    parameter int FRAC     = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_v,
    output logic        in_ready,
    input  logic [21:0] in_lane0,
    input  logic [21:0] in_lane1,
    input  logic [21:0] in_lane2,
    input  logic [21:0] in_lane3,
    output logic [13:0] pix_out,
    output logic        pix_out_v,
    input  logic        pix_out_rdy,
    output logic [9:0]  pix_idx,
    output logic        eol,
    output logic        ovf,
    input  logic        ovf_clr
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [9:0]    LAST_IDX = 10'(LINE_LEN - 1);
    localparam logic [22:0]   RND_C    = 23'(1) << (FRAC - 1);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // Round half up; the 23-bit sum keeps the carry out of 22'h3FFFFF.
    function automatic logic [13:0] round_lane(input logic [21:0] x);
        logic [22:0] sum;
        sum = {1'b0, x} + RND_C;
        return 14'(sum >> FRAC);
    endfunction

    // Word layout is {lane3, lane2, lane1, lane0}.
    function automatic logic [13:0] lane_of(input logic [55:0] w, input logic [1:0] s);
        logic [13:0] r;
        case (s)
            2'd0:    r = w[13:0];
            2'd1:    r = w[27:14];
            2'd2:    r = w[41:28];
            default: r = w[55:42];
        endcase
        return r;
    endfunction

    logic          stage_v_q, stage_v_d;
    logic [55:0]   stage_q, stage_d;
    logic [55:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [1:0]    lane_sel_q, lane_sel_d;
    logic [13:0]   pix_q, pix_d;
    logic          pix_v_q, pix_v_d;
    logic [9:0]    idx_q, idx_d;
    logic          eol_q, eol_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] occ_s;
    logic          in_ready_s, accept_s, drop_s, push_s, pop_s, xfer_s, more_s;
    logic [PW-1:0] rd_nxt_s;
    logic [55:0]   head_s, next_word_s;
    logic [9:0]    idx_inc_s;

    // The stage holds a word that is already committed to the FIFO, so it
    // counts against capacity; this keeps in_ready free of in_v/pix_out_rdy.
    assign occ_s       = cnt_q + CW'(stage_v_q);
    assign in_ready_s  = reset && (occ_s < DEPTH_C);
    assign accept_s    = in_v && in_ready_s;
    assign drop_s      = in_v && !in_ready_s;
    assign push_s      = stage_v_q;
    assign xfer_s      = pix_v_q && pix_out_rdy;
    assign head_s      = mem_q[rd_ptr_q];
    assign rd_nxt_s    = rd_ptr_q + PW'(1);
    assign more_s      = (cnt_q > CW'(1));
    // When only the head is stored, the word behind it is still in the stage
    // and is being written this cycle; take it from there so there is no bubble.
    assign next_word_s = more_s ? mem_q[rd_nxt_s] : stage_q;
    assign idx_inc_s   = (idx_q == LAST_IDX) ? 10'd0 : idx_q + 10'd1;

    // Round stage, FIFO bookkeeping and sticky overflow next-state.
    always_comb begin
        stage_v_d = accept_s;
        if (accept_s) begin
            stage_d = {round_lane(in_lane3), round_lane(in_lane2),
                       round_lane(in_lane1), round_lane(in_lane0)};
        end else begin
            stage_d = stage_q;
        end
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_nxt_s;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Serializer FSM next-state and registered-output next values.
    always_comb begin
        state_d    = state_q;
        lane_sel_d = lane_sel_q;
        pix_d      = pix_q;
        pix_v_d    = pix_v_q;
        idx_d      = idx_q;
        eol_d      = eol_q;
        pop_s      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (cnt_q != CW'(0)) begin
                    state_d    = S_SHIFT;
                    lane_sel_d = 2'd0;
                    pix_d      = lane_of(head_s, 2'd0);
                    pix_v_d    = 1'b1;
                    eol_d      = (idx_q == LAST_IDX);
                end else begin
                    pix_v_d    = 1'b0;
                    eol_d      = 1'b0;
                end
            end
            S_SHIFT: begin
                if (xfer_s) begin
                    idx_d = idx_inc_s;
                    if (lane_sel_q != 2'd3) begin
                        lane_sel_d = lane_sel_q + 2'd1;
                        pix_d      = lane_of(head_s, lane_sel_q + 2'd1);
                        eol_d      = (idx_inc_s == LAST_IDX);
                    end else begin
                        pop_s      = 1'b1;
                        lane_sel_d = 2'd0;
                        if (more_s || push_s) begin
                            pix_d = lane_of(next_word_s, 2'd0);
                            eol_d = (idx_inc_s == LAST_IDX);
                        end else begin
                            state_d = S_EMPTY;
                            pix_v_d = 1'b0;
                            eol_d   = 1'b0;
                        end
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d    = S_EMPTY;
                lane_sel_d = 2'd0;
                pix_v_d    = 1'b0;
                eol_d      = 1'b0;
            end
        endcase
    end

    // FIFO storage; no reset needed since the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= stage_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_v_q  <= 1'b0;
            stage_q    <= 56'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            state_q    <= S_EMPTY;
            lane_sel_q <= 2'd0;
            pix_q      <= 14'd0;
            pix_v_q    <= 1'b0;
            idx_q      <= 10'd0;
            eol_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            stage_v_q  <= stage_v_d;
            stage_q    <= stage_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            lane_sel_q <= lane_sel_d;
            pix_q      <= pix_d;
            pix_v_q    <= pix_v_d;
            idx_q      <= idx_d;
            eol_q      <= eol_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign pix_out   = pix_q;
    assign pix_out_v = pix_v_q;
    assign pix_idx   = idx_q;
    assign eol       = eol_q;
    assign ovf       = ovf_q;

endmodule
